// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction fetch unit with a small in-order instruction queue.
//
// Issues one instruction-memory request at a time, sequentially from fetch_pc, and
// pushes each returned word together with its byte address into a DEPTH-entry FIFO.
// A redirect flushes the queue and restarts fetching at the new (word-aligned)
// address. A redirect that arrives while a request is still outstanding leaves that
// request on the bus until its ack, and the returned word is discarded.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   imem_req_o / imem_addr_o      request and byte address to instruction memory
//   imem_ack_i / imem_data_i      response for the outstanding request
//   instr_valid_o, instr_o        queue head valid flag and instruction word
//   instr_pc_o, instr_op_o        head byte address and opcode field (instr_o[31:26])
//   instr_ready_i                 consumer pops the head
//   redirect_i, redirect_pc_i     flush and restart fetching at redirect_pc_i & ~3
//
// Optional build macro IFQ_PERF_CNT_EN adds:
//   stall_cnt_o  cycles with instr_valid_o = 0 (wrapping)
//   flush_cnt_o  cycles with redirect_i = 1 (wrapping)

module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [5:0]  instr_op_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StFlush} state_e;

  state_e          r_state;
  logic [31:0]     r_fetch_pc;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [31:0]     r_data [DEPTH];
  logic [31:0]     r_pc   [DEPTH];

  logic            w_head_valid;
  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_count_d;
  logic [31:0]     w_redirect_pc;
  logic [31:0]     w_pc_inc;

  assign w_head_valid  = (r_count != '0);
  // A redirect overrides both queue operations in the same cycle.
  assign w_push        = (r_state == StReq) && imem_ack_i && !redirect_i;
  assign w_pop         = w_head_valid && instr_ready_i && !redirect_i;
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_pc_inc      = r_fetch_pc + 32'd4;

  always_comb begin
    w_count_d = r_count;
    if (redirect_i) begin
      w_count_d = '0;
    end else if (w_push && !w_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - 1'b1;
    end
  end

  // Fetch FSM. r_fetch_pc is the address of the outstanding request while in StReq,
  // otherwise the address of the next request to issue. In StFlush r_addr keeps the
  // abandoned request's address on the bus while r_fetch_pc already holds the target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      case (r_state)
        StIdle: begin
          if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
          end else if (r_count < DepthC) begin
            r_state <= StReq;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        StReq: begin
          if (imem_ack_i) begin
            if (redirect_i) begin
              r_fetch_pc <= w_redirect_pc;
              r_state    <= StIdle;
              r_req      <= 1'b0;
            end else begin
              r_fetch_pc <= w_pc_inc;
              if (w_count_d < DepthC) begin
                r_addr <= w_pc_inc;
              end else begin
                r_state <= StIdle;
                r_req   <= 1'b0;
              end
            end
          end else if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
            r_state    <= StFlush;
          end
        end
        StFlush: begin
          if (redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
          end
          if (imem_ack_i) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_d;
      if (redirect_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: every read of it is qualified by a non-zero count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_tail] <= imem_data_i;
      r_pc[r_tail]   <= r_addr;
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = w_head_valid;
  assign instr_o       = w_head_valid ? r_data[r_head] : 32'd0;
  assign instr_pc_o    = w_head_valid ? r_pc[r_head]   : 32'd0;
  assign instr_op_o    = instr_o[31:26];

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!w_head_valid) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (redirect_i) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a randomized
// run against a transaction-level model (expected-entry queue, next fetch address,
// and a flag for a request abandoned by a redirect).

module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [5:0]  instr_op_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_op_o    (instr_op_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef IFQ_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
`endif
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic idle_inputs();
    imem_ack_i    = 1'b0;
    imem_data_i   = '0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
  endtask

  // Leaves the bench one negedge after release: first request already raised.
  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++;
      $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== RESET_PC) begin errors++;
      $display("FAIL reset_addr: got %h want %h", imem_addr_o, RESET_PC); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
    checks++; if (instr_o !== 32'd0 || instr_pc_o !== 32'd0 || instr_op_o !== 6'd0) begin
      errors++;
      $display("FAIL reset_instr: got %h/%h/%h want 0/0/0", instr_o, instr_pc_o, instr_op_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin errors++;
      $display("FAIL reset_first_req: got %b@%h want 1@%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    checks++; if (instr_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_first_valid: got %b want 0", instr_valid_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] prev;
    do_reset();
    instr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_addr = 32'(4 * i);
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_addr) begin errors++;
        $display("FAIL stream_addr: got %b@%h want 1@%h", imem_req_o, imem_addr_o, exp_addr);
      end
      if (i == 0) begin
        checks++; if (instr_valid_o !== 1'b0) begin errors++;
          $display("FAIL stream_first_valid: got %b want 0", instr_valid_o); end
      end else begin
        prev = 32'(4 * (i - 1));
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== prev || instr_o !== mem_word(prev)) begin
          errors++;
          $display("FAIL stream_head: got %b pc=%h ins=%h want 1 pc=%h ins=%h",
                   instr_valid_o, instr_pc_o, instr_o, prev, mem_word(prev));
        end
      end
      imem_ack_i  = 1'b1;
      imem_data_i = mem_word(exp_addr);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * i)) begin errors++;
        $display("FAIL fill_addr: got %b@%h want 1@%h", imem_req_o, imem_addr_o, 32'(4 * i));
      end
      imem_ack_i  = 1'b1;
      imem_data_i = mem_word(32'(4 * i));
      @(negedge clk);
    end
    imem_ack_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0) begin errors++;
      $display("FAIL fill_full_req: got %b want 0", imem_req_o); end
    repeat (3) @(negedge clk);
    checks++; if (imem_req_o !== 1'b0 || instr_pc_o !== 32'd0) begin errors++;
      $display("FAIL fill_hold: got req=%b pc=%h want req=0 pc=0", imem_req_o, instr_pc_o);
    end
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    for (int k = 0; k < 4 && imem_req_o !== 1'b1; k++) @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd16) begin errors++;
      $display("FAIL fill_refill: got %b@%h want 1@00000010", imem_req_o, imem_addr_o);
    end
    for (int j = 0; j < 3; j++) begin
      exp_pc = 32'(4 * (j + 1));
      checks++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL fill_drain: got %b pc=%h ins=%h want 1 pc=%h ins=%h",
                 instr_valid_o, instr_pc_o, instr_o, exp_pc, mem_word(exp_pc));
      end
      instr_ready_i = 1'b1;
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0) begin errors++;
      $display("FAIL fill_empty: got %b want 0", instr_valid_o); end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem_ack_i  = 1'b1;
      imem_data_i = mem_word(32'(4 * i));
      @(negedge clk);
    end
    imem_ack_i    = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd8 || instr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL stale_hold: got req=%b addr=%h valid=%b want 1/00000008/0",
                 imem_req_o, imem_addr_o, instr_valid_o);
      end
      @(negedge clk);
    end
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++;
      $display("FAIL stale_drop: got valid=%b req=%b want 0/0", instr_valid_o, imem_req_o);
    end
    @(negedge clk);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_newreq: got req=%b addr=%h valid=%b want 1/00000100/0",
               imem_req_o, imem_addr_o, instr_valid_o);
    end
    imem_ack_i  = 1'b1;
    imem_data_i = mem_word(32'h100);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100 || instr_o !== mem_word(32'h100)
        || instr_op_o !== mem_word(32'h100) >> 26) begin
      errors++;
      $display("FAIL stale_first: got %b pc=%h ins=%h op=%h", instr_valid_o, instr_pc_o,
               instr_o, instr_op_o);
    end
  endtask

  task automatic test_redirect_ack_pop();
    logic [31:0] r;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem_ack_i  = 1'b1;
      imem_data_i = mem_word(32'(4 * i));
      @(negedge clk);
    end
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'd0) begin errors++;
      $display("FAIL rap_pre: got %b pc=%h want 1 pc=0", instr_valid_o, instr_pc_o); end
    r             = $urandom();
    tgt           = {r[31:2], 2'b00};
    imem_ack_i    = 1'b1;
    imem_data_i   = mem_word(32'd8);
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = {r[31:2], 2'b11};
    @(negedge clk);
    idle_inputs();
    checks++;
    if (instr_valid_o !== 1'b0 || instr_op_o !== 6'd0 || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rap_flush: got valid=%b op=%h req=%b want 0/0/0", instr_valid_o,
               instr_op_o, imem_req_o);
    end
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== tgt || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rap_target: got req=%b addr=%h valid=%b want 1/%h/0", imem_req_o,
               imem_addr_o, instr_valid_o, tgt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ack_i    = 1'b1;
    imem_data_i   = 32'h1234_5678;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_top: got %b@%h want 1@fffffffc", imem_req_o, imem_addr_o); end
    imem_ack_i  = 1'b1;
    imem_data_i = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    imem_ack_i = 1'b0;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin errors++;
      $display("FAIL wrap_next: got %b@%h want 1@00000000", imem_req_o, imem_addr_o); end
    checks++;
    if (instr_pc_o !== 32'hFFFF_FFFC || instr_o !== mem_word(32'hFFFF_FFFC)) begin errors++;
      $display("FAIL wrap_head: got pc=%h ins=%h want pc=fffffffc ins=%h", instr_pc_o, instr_o,
               mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      imem_ack_i  = 1'b1;
      imem_data_i = mem_word(32'(4 * i));
      @(negedge clk);
    end
    imem_ack_i = 1'b0;
    rst_i      = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'd0
        || instr_pc_o !== 32'd0 || imem_addr_o !== RESET_PC) begin
      errors++;
      $display("FAIL midrst_async: got req=%b valid=%b ins=%h pc=%h addr=%h", imem_req_o,
               instr_valid_o, instr_o, instr_pc_o, imem_addr_o);
    end
    @(negedge clk);
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hBAD0_0BAD;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin errors++;
      $display("FAIL midrst_ack_in_rst: got req=%b valid=%b", imem_req_o, instr_valid_o); end
    // Late ack still on the bus during the first cycle after release.
    rst_i = 1'b0;
    @(negedge clk);
    imem_ack_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: got req=%b addr=%h valid=%b want 1/%h/0", imem_req_o,
               imem_addr_o, instr_valid_o, RESET_PC);
    end
    @(negedge clk);
    checks++; if (instr_valid_o !== 1'b0 || imem_addr_o !== RESET_PC) begin errors++;
      $display("FAIL midrst_ignored: got valid=%b addr=%h", instr_valid_o, imem_addr_o); end
    imem_ack_i  = 1'b1;
    imem_data_i = mem_word(RESET_PC);
    @(negedge clk);
    idle_inputs();
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== RESET_PC || instr_o !== mem_word(RESET_PC))
    begin
      errors++;
      $display("FAIL midrst_first: got %b pc=%h ins=%h", instr_valid_o, instr_pc_o, instr_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] fetch_pc;
    logic [31:0] stale_addr;
    logic [31:0] want;
    logic [31:0] raw;
    bit          stale;
    bit          req;
    bit          ack;
    bit          rdy;
    bit          redir;
    do_reset();
    fetch_pc   = RESET_PC;
    stale      = 1'b0;
    stale_addr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (instr_valid_o !== (exp_q.size() > 0)) begin errors++;
        $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, instr_valid_o, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        want = mem_word(exp_q[0]);
        checks++;
        if (instr_pc_o !== exp_q[0] || instr_o !== want || instr_op_o !== want[31:26]) begin
          errors++;
          $display("FAIL rnd_head: cyc %0d got pc=%h ins=%h op=%h want pc=%h ins=%h", cyc,
                   instr_pc_o, instr_o, instr_op_o, exp_q[0], want);
        end
      end else begin
        checks++; if (instr_op_o !== 6'd0) begin errors++;
          $display("FAIL rnd_op_empty: cyc %0d got %h want 0", cyc, instr_op_o); end
      end
      req = (imem_req_o === 1'b1);
      if (req) begin
        want = stale ? stale_addr : fetch_pc;
        checks++; if (imem_addr_o !== want) begin errors++;
          $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, imem_addr_o, want); end
      end
      if (exp_q.size() == DEPTH) begin
        checks++; if (imem_req_o !== 1'b0) begin errors++;
          $display("FAIL rnd_full_req: cyc %0d got %b want 0", cyc, imem_req_o); end
      end
      ack   = req && ($urandom_range(2) != 0);
      rdy   = ($urandom_range(1) != 0);
      redir = ($urandom_range(15) == 0);
      raw   = $urandom();
      imem_ack_i    = ack;
      imem_data_i   = ack ? mem_word(imem_addr_o) : 32'h0;
      instr_ready_i = rdy;
      redirect_i    = redir;
      redirect_pc_i = raw;
      // Model of what the coming edge does.
      if (redir) begin
        if (req && ack) stale = 1'b0;
        else if (req && !stale) begin
          stale      = 1'b1;
          stale_addr = fetch_pc;
        end
        exp_q.delete();
        fetch_pc = raw & ~32'd3;
      end else begin
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ack) begin
          if (stale) stale = 1'b0;
          else begin
            exp_q.push_back(fetch_pc);
            fetch_pc = fetch_pc + 32'd4;
          end
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_fill();
    test_redirect_stale();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
